// File: rtl/cpu_params_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_params_pkg
// Description : CPU-wide parameters shared by the internal I/O blocks.
//               Holds the internal I/O address window, the CLINT-style timer
//               base addresses, the timer register word offsets, the 64-bit
//               timer type, and a byte-enable merge helper.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_params_pkg;

  // Internal I/O window and per-block base addresses
  localparam logic [31:0] Int_IO_Addr_Lo     = 32'h0200_0000;
  localparam logic [31:0] Int_IO_Addr_Hi     = 32'h0200_2007;
  localparam logic [31:0] MSIP_Base_Addr     = 32'h0200_0000;
  localparam logic [31:0] MTIME_Base_Addr    = 32'h0200_1000;
  localparam logic [31:0] MTIMECMP_Base_Addr = 32'h0200_2000;

  // Word offsets of the timer registers from their base addresses
  localparam logic [31:0] MSIP_OFS        = 32'h0000_0000;
  localparam logic [31:0] MTIME_LO_OFS    = 32'h0000_0000;
  localparam logic [31:0] MTIME_HI_OFS    = 32'h0000_0004;
  localparam logic [31:0] MTIMECMP_LO_OFS = 32'h0000_0000;
  localparam logic [31:0] MTIMECMP_HI_OFS = 32'h0000_0004;

  // Width of the mtime prescale counter (PRESCALE is at most 65535)
  localparam int PRESCALE_W = 16;

  typedef logic [63:0] timer_t;

  // Register selected by the current access address
  typedef enum logic [2:0] {
    SEL_NONE     = 3'd0,
    SEL_MSIP     = 3'd1,
    SEL_MTIME_LO = 3'd2,
    SEL_MTIME_HI = 3'd3,
    SEL_CMP_LO   = 3'd4,
    SEL_CMP_HI   = 3'd5
  } reg_sel_e;

  // Replace only the byte lanes whose enable bit is set
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] result;
    result = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) result[8*i +: 8] = new_word[8*i +: 8];
    end
    return result;
  endfunction

endpackage : cpu_params_pkg
`default_nettype wire

// File: rtl/mtime_counter.sv
`default_nettype none
// ============================================================================
// Module      : mtime_counter
// Description : Prescaler plus 64-bit free-running mtime counter with a
//               parallel load port. mtime advances by one on each cycle the
//               prescaler wraps (PRESCALE clk_in cycles per tick). A load
//               overrides the increment and restarts the prescale phase.
// Ports       : clk_in      - clock
//               reset_in_n  - asynchronous active-low reset
//               load_en     - load load_value into mtime this cycle
//               load_value  - full 64-bit value to load
//               mtime_out   - current mtime
// Revision    : 1.0 - initial release
// ============================================================================
module mtime_counter
  import cpu_params_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic   clk_in,
  input  logic   reset_in_n,
  input  logic   load_en,
  input  timer_t load_value,
  output timer_t mtime_out
);

  localparam logic [PRESCALE_W-1:0] c_PRESC_LAST = PRESCALE_W'(PRESCALE - 1);

  logic [PRESCALE_W-1:0] r_presc;
  timer_t                r_mtime;
  logic                  w_wrap;

  // With PRESCALE=1 the prescaler sits at 0 and wraps every cycle
  assign w_wrap = (r_presc == c_PRESC_LAST);

  always_ff @(posedge clk_in or negedge reset_in_n) begin
    if (!reset_in_n) begin
      r_presc <= '0;
      r_mtime <= '0;
    end else if (load_en) begin
      // A software write wins over the tick and restarts the phase
      r_presc <= '0;
      r_mtime <= load_value;
    end else if (w_wrap) begin
      r_presc <= '0;
      r_mtime <= r_mtime + 64'd1;   // wraps from all-ones to zero silently
    end else begin
      r_presc <= r_presc + PRESCALE_W'(1);
    end
  end

  assign mtime_out = r_mtime;

endmodule : mtime_counter
`default_nettype wire

// File: rtl/mtimer_io.sv
`default_nettype none
// ============================================================================
// Module      : mtimer_io
// Description : Machine timer / software interrupt block on the internal
//               I/O bus. Decodes MSIP, mtime lo/hi and mtimecmp lo/hi word
//               accesses, completes each with a one-cycle ack pulse the
//               cycle after acceptance, and drives registered mtip/msip.
// Ports       : clk_in, reset_in_n      - clock, async active-low reset
//               req_in, wr_in           - access request, 1=store 0=load
//               addr_in, wdata_in, be_in- byte address, store data, enables
//               ack_out                 - one-cycle completion pulse
//               rdata_out, fault_out    - load data / access fault with ack
//               mtip_out, msip_out      - timer / software interrupt pending
// Revision    : 1.0 - initial release
// ============================================================================
module mtimer_io
  import cpu_params_pkg::*;
#(
  parameter logic [31:0] MSIP_ADDR     = MSIP_Base_Addr,
  parameter logic [31:0] MTIME_ADDR    = MTIME_Base_Addr,
  parameter logic [31:0] MTIMECMP_ADDR = MTIMECMP_Base_Addr,
  parameter int unsigned PRESCALE      = 1
) (
  input  logic        clk_in,
  input  logic        reset_in_n,
  input  logic        req_in,
  input  logic        wr_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  input  logic [3:0]  be_in,
  output logic        ack_out,
  output logic [31:0] rdata_out,
  output logic        fault_out,
  output logic        mtip_out,
  output logic        msip_out
);

  logic        r_ack;
  logic [31:0] r_rdata;
  logic        r_fault;
  logic        r_mtip;
  logic        r_msip;
  timer_t      r_mtimecmp;

  reg_sel_e    w_sel;
  logic        w_accept;
  logic        w_bad;
  logic        w_wr;
  logic [31:0] w_rd_data;
  timer_t      w_mtime;
  logic        w_mtime_load;
  timer_t      w_mtime_value;

  // A request arriving while the previous ack is showing is dropped; the
  // requester re-presents it, so only one access is ever in flight.
  assign w_accept = req_in & ~r_ack;

  // Address decode: only exact, word-aligned register addresses select
  always_comb begin
    w_sel = SEL_NONE;
    if (addr_in[1:0] == 2'b00) begin
      if (addr_in == MSIP_ADDR + MSIP_OFS)                 w_sel = SEL_MSIP;
      else if (addr_in == MTIME_ADDR + MTIME_LO_OFS)       w_sel = SEL_MTIME_LO;
      else if (addr_in == MTIME_ADDR + MTIME_HI_OFS)       w_sel = SEL_MTIME_HI;
      else if (addr_in == MTIMECMP_ADDR + MTIMECMP_LO_OFS) w_sel = SEL_CMP_LO;
      else if (addr_in == MTIMECMP_ADDR + MTIMECMP_HI_OFS) w_sel = SEL_CMP_HI;
    end
  end

  assign w_bad = (w_sel == SEL_NONE);
  // be_in=0 completes normally but leaves every register untouched
  assign w_wr  = w_accept & wr_in & ~w_bad & (|be_in);

  // Load data reflects register contents before this edge's update
  always_comb begin
    w_rd_data = '0;
    case (w_sel)
      SEL_MSIP:     w_rd_data = {31'd0, r_msip};
      SEL_MTIME_LO: w_rd_data = w_mtime[31:0];
      SEL_MTIME_HI: w_rd_data = w_mtime[63:32];
      SEL_CMP_LO:   w_rd_data = r_mtimecmp[31:0];
      SEL_CMP_HI:   w_rd_data = r_mtimecmp[63:32];
      default:      w_rd_data = '0;
    endcase
  end

  // A half-word store rebuilds the full 64-bit value; the other half is
  // taken as-is, so no carry crosses between halves.
  assign w_mtime_load = w_wr & ((w_sel == SEL_MTIME_LO) | (w_sel == SEL_MTIME_HI));

  always_comb begin
    w_mtime_value = w_mtime;
    if (w_sel == SEL_MTIME_HI)
      w_mtime_value[63:32] = merge_bytes(w_mtime[63:32], wdata_in, be_in);
    else
      w_mtime_value[31:0]  = merge_bytes(w_mtime[31:0], wdata_in, be_in);
  end

  mtime_counter #(
    .PRESCALE   (PRESCALE)
  ) u_mtime_counter (
    .clk_in     (clk_in),
    .reset_in_n (reset_in_n),
    .load_en    (w_mtime_load),
    .load_value (w_mtime_value),
    .mtime_out  (w_mtime)
  );

  always_ff @(posedge clk_in or negedge reset_in_n) begin
    if (!reset_in_n) begin
      r_ack      <= 1'b0;
      r_rdata    <= '0;
      r_fault    <= 1'b0;
      r_mtip     <= 1'b0;
      r_msip     <= 1'b0;
      r_mtimecmp <= '1;
    end else begin
      r_ack   <= w_accept;
      r_fault <= w_accept & w_bad;
      r_rdata <= (w_accept & ~wr_in & ~w_bad) ? w_rd_data : '0;

      // Compare the settled registers, so a mtimecmp store shows on mtip
      // one cycle after its ack and an mtime tick one cycle after it lands.
      r_mtip  <= (w_mtime >= r_mtimecmp);

      if (w_wr && (w_sel == SEL_MSIP) && be_in[0])
        r_msip <= wdata_in[0];
      if (w_wr && (w_sel == SEL_CMP_LO))
        r_mtimecmp[31:0]  <= merge_bytes(r_mtimecmp[31:0], wdata_in, be_in);
      if (w_wr && (w_sel == SEL_CMP_HI))
        r_mtimecmp[63:32] <= merge_bytes(r_mtimecmp[63:32], wdata_in, be_in);
    end
  end

  assign ack_out   = r_ack;
  assign rdata_out = r_rdata;
  assign fault_out = r_fault;
  assign mtip_out  = r_mtip;
  assign msip_out  = r_msip;

endmodule : mtimer_io
`default_nettype wire
